fft_frame_packer: RTL
=====================

// Module: fft_frame_packer
// PURPOSE
//  Upstream feeder for the streaming FFT core. Takes a continuous real ADC sample stream,
//  buffers it in a small FWFT FIFO, and emits Avalon-ST packets of frame_len samples
//  (sop/eop framed, imag=0, error=0, inverse=0) on the FFT sink interface. Honours sink_ready
//  backpressure; flags ADC samples lost to overflow.
// PARAMETERS
//  DATA_W      14    sample width, signed two's complement (matches FFT sink_real/sink_imag)
//  PTS_W       11    width of frame length / fftpts field
//  FIFO_AW     4     FIFO address width; depth = 2**FIFO_AW = 16
//  MAX_PTS     1024  largest legal frame length
// PORTS
//  clk          in   1        clock
//  reset_n      in   1        synchronous active-low reset
//  enable       in   1        1 = start/continue framing; 0 = stop after current frame
//  adc_valid    in   1        ADC sample strobe
//  adc_data     in   DATA_W   ADC sample
//  frame_len    in   PTS_W    requested points (64,128,256,512,1024); sampled at frame start
//  fft_valid    out  1        -> FFT sink_valid
//  fft_ready    in   1        <- FFT sink_ready
//  fft_sop      out  1        -> sink_sop
//  fft_eop      out  1        -> sink_eop
//  fft_error    out  2        -> sink_error, constant 2'b00
//  fft_real     out  DATA_W   -> sink_real
//  fft_imag     out  DATA_W   -> sink_imag, constant 0
//  fft_pts      out  PTS_W    -> fftpts_in, latched length of current frame
//  fft_inverse  out  1        -> inverse, constant 0
//  overflow     out  1        one-cycle pulse per dropped ADC sample
//  busy         out  1        1 while state==STREAM
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): FIFO flushed, state IDLE, beat count 0, fft_pts=MAX_PTS;
//   all outputs 0 except fft_pts. Reset mid-frame aborts it; no eop is emitted.
//  Handshake: beat transfers on cycle where fft_valid && fft_ready. fft_valid = state==STREAM
//   && FIFO non-empty. While fft_valid=1 and fft_ready=0, all fft_* outputs hold stable.
//  Intake gate: ADC sample written iff adc_valid && (enable || state==STREAM).
//  FIFO: FWFT; sample written at edge N visible on fft_real from cycle N+1 (1-cycle latency).
//   Write when full is accepted only if a read handshake occurs in the same cycle; otherwise
//   sample dropped and overflow=1 next cycle. Empty read impossible (fft_valid gated).
//   Pointers FIFO_AW+1 bits, wrap naturally; full = MSBs differ, low bits equal.
//  FSM:
//   IDLE   : if enable -> latch frame_len into pts_q (illegal value -> MAX_PTS), cnt=0, ->STREAM
//   STREAM : per handshake cnt++; fft_sop = (cnt==0); fft_eop = (cnt==pts_q-1).
//            on eop handshake: cnt=0; if enable re-latch frame_len, stay STREAM; else ->IDLE.
//  enable drop mid-frame: frame completes normally (intake stays open until eop).
//  frame_len change mid-frame ignored until next frame start.
//  fft_pts = pts_q, stable for the whole frame.
// CONFIGURATION
//  FFT_PACK_DROP_CNT_EN defined: extra output drop_cnt [15:0], saturating count of dropped
//   samples, cleared by reset only; also cleared on first sop handshake after enable 0->1.
//  Undefined: drop_cnt port absent; overflow pulse is the only loss indication.
// TESTING
//  1) frame_len=64, enable=1, adc_valid every cycle, fft_ready=1 -> 64-beat packets,
//     sop on beat 0, eop on beat 63, data in order, first fft_valid 1 cycle after first sample.
//  2) Toggle fft_ready 1/0 every cycle, adc_valid 1 in 3 -> no loss, outputs hold while stalled.
//  3) fft_ready=0 for 20 cycles, adc_valid continuous -> 16 stored, overflow pulses 4 times,
//     drop_cnt=4 (with FFT_PACK_DROP_CNT_EN).
//  4) enable 1->0 at beat 10 of 128-pt frame -> frame finishes at beat 127 eop, then IDLE, busy=0.
//  5) frame_len=100 (illegal) -> fft_pts=1024, eop on beat 1023; change frame_len to 256 mid-frame
//     -> next frame fft_pts=256.
//  6) reset_n=0 for 1 cycle at beat 30 -> all outputs 0, FIFO empty; next frame restarts with sop.

Source files
------------

// File: rtl/fft_frame_packer_if.sv
// ---------------------------------------------------------------------------
// fft_sink_if
// Avalon-ST sink bundle of the streaming FFT core, as seen by its feeder.
//   fft_valid   : beat valid (sink_valid)
//   fft_ready   : core can accept a beat (sink_ready)
//   fft_sop     : first beat of a frame
//   fft_eop     : last beat of a frame
//   fft_error   : sink_error
//   fft_real    : real part of the sample
//   fft_imag    : imaginary part of the sample
//   fft_pts     : frame length (fftpts_in)
//   fft_inverse : inverse-transform select
// Modports: master = feeder side (drives everything but fft_ready),
//           slave  = FFT core side.
// ---------------------------------------------------------------------------
interface fft_sink_if #(
    parameter int DATA_W = 14,
    parameter int PTS_W  = 11
);
    logic              fft_valid;
    logic              fft_ready;
    logic              fft_sop;
    logic              fft_eop;
    logic [1:0]        fft_error;
    logic [DATA_W-1:0] fft_real;
    logic [DATA_W-1:0] fft_imag;
    logic [PTS_W-1:0]  fft_pts;
    logic              fft_inverse;

    modport master (
        output fft_valid, fft_sop, fft_eop, fft_error,
               fft_real, fft_imag, fft_pts, fft_inverse,
        input  fft_ready
    );

    modport slave (
        input  fft_valid, fft_sop, fft_eop, fft_error,
               fft_real, fft_imag, fft_pts, fft_inverse,
        output fft_ready
    );
endinterface

// File: rtl/fft_frame_packer.sv
// ---------------------------------------------------------------------------
// fft_frame_packer
// Feeds the streaming FFT core from a real ADC sample stream. Samples go
// through a 2**FIFO_AW deep first-word-fall-through FIFO and leave as
// sop/eop framed packets of frame_len beats (imag, error, inverse all zero).
// Samples arriving while the FIFO is full and not being read are dropped and
// reported with a one-cycle overflow pulse.
//
// Ports
//   clk          : clock
//   reset_n      : synchronous active-low reset
//   enable_i     : 1 = start/continue framing, 0 = stop after current frame
//   adc_valid_i  : ADC sample strobe
//   adc_data_i   : ADC sample, signed
//   frame_len_i  : requested frame length, sampled at frame start
//   snk          : FFT sink bundle (fft_sink_if.master)
//   overflow_o   : one-cycle pulse per dropped sample
//   busy_o       : high while streaming a frame
//   drop_cnt_o   : saturating drop counter (only with FFT_PACK_DROP_CNT_EN)
//
// Build option: define FFT_PACK_DROP_CNT_EN to add drop_cnt_o.
// ---------------------------------------------------------------------------
module fft_frame_packer #(
    parameter int DATA_W  = 14,
    parameter int PTS_W   = 11,
    parameter int FIFO_AW = 4,
    parameter int MAX_PTS = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              adc_valid_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic [PTS_W-1:0]  frame_len_i,
    fft_sink_if.master        snk,
    output logic              overflow_o,
    output logic              busy_o
`ifdef FFT_PACK_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int                 DEPTH   = 1 << FIFO_AW;
    localparam logic [PTS_W-1:0]   PTS_ONE = PTS_W'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE = (FIFO_AW+1)'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Only the FFT core's supported sizes pass; anything else runs at full size.
    function automatic logic [PTS_W-1:0] legal_pts(input logic [PTS_W-1:0] len);
        case (len)
            PTS_W'(64), PTS_W'(128), PTS_W'(256),
            PTS_W'(512), PTS_W'(1024): legal_pts = len;
            default:                   legal_pts = PTS_W'(MAX_PTS);
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [PTS_W-1:0]   cnt_q, cnt_d;
    logic [PTS_W-1:0]   pts_q, pts_d;
    logic               overflow_q;
    logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic empty_s, full_s, valid_s, rd_hs_s, wr_req_s, wr_en_s, drop_s, last_s;

    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign valid_s  = (state_q == S_STREAM) && !empty_s;
    assign rd_hs_s  = valid_s && snk.fft_ready;
    // Intake stays open until the running frame's eop even after enable drops.
    assign wr_req_s = adc_valid_i && (enable_i || (state_q == S_STREAM));
    // A full FIFO still takes the sample when a beat leaves in the same cycle.
    assign wr_en_s  = wr_req_s && (!full_s || rd_hs_s);
    assign drop_s   = wr_req_s && !wr_en_s;
    assign last_s   = (cnt_q == (pts_q - PTS_ONE));

    // Next-state logic: frame start, beat counting and end-of-frame decision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pts_d   = pts_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    pts_d   = legal_pts(frame_len_i);
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (rd_hs_s) begin
                    if (last_s) begin
                        cnt_d = '0;
                        if (enable_i) begin
                            pts_d   = legal_pts(frame_len_i);
                            state_d = S_STREAM;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + PTS_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pts_q      <= PTS_W'(MAX_PTS);
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pts_q      <= pts_d;
            overflow_q <= drop_s;
        end
    end

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            else         wr_ptr_q <= wr_ptr_q;
            if (rd_hs_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            else         rd_ptr_q <= rd_ptr_q;
        end
    end

    // FIFO storage; contents need no reset since outputs are gated by valid
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= adc_data_i;
    end

    // Sink outputs; data is forced to zero whenever no beat is offered
    always_comb begin
        snk.fft_valid   = valid_s;
        snk.fft_sop     = valid_s && (cnt_q == '0);
        snk.fft_eop     = valid_s && last_s;
        snk.fft_error   = 2'b00;
        snk.fft_real    = valid_s ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : '0;
        snk.fft_imag    = '0;
        snk.fft_pts     = pts_q;
        snk.fft_inverse = 1'b0;
        overflow_o      = overflow_q;
        busy_o          = (state_q == S_STREAM);
    end

`ifdef FFT_PACK_DROP_CNT_EN
    logic        enable_q;
    logic        clr_arm_q;
    logic [15:0] drop_cnt_q;
    logic        sop_hs_s;

    assign sop_hs_s = rd_hs_s && (cnt_q == '0);

    // Drop counter: armed to clear by an enable rise, cleared at the next sop beat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            clr_arm_q  <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            enable_q <= enable_i;
            if (enable_i && !enable_q) clr_arm_q <= 1'b1;
            else if (sop_hs_s)         clr_arm_q <= 1'b0;
            else                       clr_arm_q <= clr_arm_q;
            if (clr_arm_q && sop_hs_s)
                drop_cnt_q <= {15'd0, drop_s};
            else if (drop_s && (drop_cnt_q != 16'hFFFF))
                drop_cnt_q <= drop_cnt_q + 16'd1;
            else
                drop_cnt_q <= drop_cnt_q;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
